// File: rtl/fpu_issue_pkg.sv
// Shared op-codes, state encoding and helpers for the FPU issue controller.
package fpu_issue_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADD      = 3'b000;
    localparam logic [2:0] SUB      = 3'b001;
    localparam logic [2:0] MULT     = 3'b010;
    localparam logic [2:0] IDLE_SEL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == ADD) || (op == SUB) || (op == MULT);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding request issuer for a downstream FPU, with response timeout.
// Optional performance counters are enabled with FPU_ISSUE_PERF_CNT_EN.
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    input  logic [2:0]        req_op,
    output logic [DATA_W-1:0] fpu_op1,
    output logic [DATA_W-1:0] fpu_op2,
    output logic [2:0]        fpu_op_sel,
    input  logic [DATA_W-1:0] fpu_result,
    input  logic              fpu_data_valid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err
`ifdef FPU_ISSUE_PERF_CNT_EN
    ,
    output logic [15:0]       ops_done,
    output logic [7:0]        timeouts
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             load_op;
    logic             load_ill;
    logic             cap_ok;
    logic             cap_to;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             rsp_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_op  = 1'b0;
        load_ill = 1'b0;
        cap_ok   = 1'b0;
        cap_to   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_legal_op(req_op)) begin
                        load_op = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        load_ill = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (fpu_data_valid) begin
                    cap_ok  = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cap_to  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpu_op1    <= '0;
            fpu_op2    <= '0;
            fpu_op_sel <= IDLE_SEL;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (load_op) begin
                fpu_op1    <= req_op1;
                fpu_op2    <= req_op2;
                fpu_op_sel <= req_op;
            end else if (rsp_done) begin
                fpu_op_sel <= IDLE_SEL;
            end
            if (cap_ok) begin
                rsp_result <= fpu_result;
                rsp_err    <= 1'b0;
            end else if (load_ill || cap_to) begin
                rsp_result <= '0;
                rsp_err    <= 1'b1;
            end
        end
    end

`ifdef FPU_ISSUE_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ops_done <= '0;
            timeouts <= '0;
        end else begin
            if (rsp_done) begin
                ops_done <= sat_inc16(ops_done);
            end
            if (cap_to) begin
                timeouts <= sat_inc8(timeouts);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl against a transaction-level model.
// Define FPU_ISSUE_PERF_CNT_EN to also check the performance counters.
module tb_fpu_issue_ctrl;

    localparam int TO  = 8;
    localparam int TO4 = 4;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [2:0]  req_op;
    logic [31:0] fpu_op1;
    logic [31:0] fpu_op2;
    logic [2:0]  fpu_op_sel;
    logic [31:0] fpu_result;
    logic        fpu_data_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;

    logic        t4_req_valid;
    logic        t4_req_ready;
    logic [31:0] t4_fpu_op1;
    logic [31:0] t4_fpu_op2;
    logic [2:0]  t4_fpu_op_sel;
    logic        t4_fpu_data_valid;
    logic        t4_rsp_valid;
    logic        t4_rsp_ready;
    logic [31:0] t4_rsp_result;
    logic        t4_rsp_err;

`ifdef FPU_ISSUE_PERF_CNT_EN
    logic [15:0] ops_done;
    logic [7:0]  timeouts;
    logic [15:0] t4_ops_done;
    logic [7:0]  t4_timeouts;
`endif

    int total = 0;
    int bad   = 0;
    int exp_done = 0;
    int exp_to   = 0;

    fpu_issue_ctrl #(.TIMEOUT(TO)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op1        (req_op1),
        .req_op2        (req_op2),
        .req_op         (req_op),
        .fpu_op1        (fpu_op1),
        .fpu_op2        (fpu_op2),
        .fpu_op_sel     (fpu_op_sel),
        .fpu_result     (fpu_result),
        .fpu_data_valid (fpu_data_valid),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_err        (rsp_err)
`ifdef FPU_ISSUE_PERF_CNT_EN
        ,
        .ops_done       (ops_done),
        .timeouts       (timeouts)
`endif
    );

    fpu_issue_ctrl #(.TIMEOUT(TO4)) u_dut_t4 (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (t4_req_valid),
        .req_ready      (t4_req_ready),
        .req_op1        (req_op1),
        .req_op2        (req_op2),
        .req_op         (req_op),
        .fpu_op1        (t4_fpu_op1),
        .fpu_op2        (t4_fpu_op2),
        .fpu_op_sel     (t4_fpu_op_sel),
        .fpu_result     (fpu_result),
        .fpu_data_valid (t4_fpu_data_valid),
        .rsp_valid      (t4_rsp_valid),
        .rsp_ready      (t4_rsp_ready),
        .rsp_result     (t4_rsp_result),
        .rsp_err        (t4_rsp_err)
`ifdef FPU_ISSUE_PERF_CNT_EN
        ,
        .ops_done       (t4_ops_done),
        .timeouts       (t4_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     32'(req_ready),  32'd1);
        check({tag, "_op1"},       fpu_op1,         32'd0);
        check({tag, "_op2"},       fpu_op2,         32'd0);
        check({tag, "_sel"},       32'(fpu_op_sel), 32'd7);
        check({tag, "_rsp_valid"}, 32'(rsp_valid),  32'd0);
        check({tag, "_rsp_res"},   rsp_result,      32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),    32'd0);
    endtask

    // One full transaction: lat = index of the WAIT cycle carrying fpu_data_valid
    // (lat >= TO means the FPU never answers), stall = cycles rsp_ready is held low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] val, input int stall);
        bit          legal;
        bit          err;
        logic [31:0] exp_res;
        int          wait_n;
        legal   = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
        err     = !legal || (lat >= TO);
        exp_res = err ? 32'd0 : val;
        wait_n  = (lat < TO) ? lat : TO - 1;

        @(negedge clk);
        check("idle_ready",     32'(req_ready),  32'd1);
        check("idle_sel",       32'(fpu_op_sel), 32'd7);
        check("idle_rsp_valid", 32'(rsp_valid),  32'd0);
        req_valid      = 1'b1;
        req_op         = op;
        req_op1        = a;
        req_op2        = b;
        fpu_data_valid = 1'($urandom_range(0, 1));
        fpu_result     = $urandom;
        rsp_ready      = 1'($urandom_range(0, 1));

        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_op1   = $urandom;
        req_op2   = $urandom;
        if (legal) begin
            check("issue_rsp_valid", 32'(rsp_valid),  32'd0);
            check("issue_ready",     32'(req_ready),  32'd0);
            check("issue_sel",       32'(fpu_op_sel), 32'(op));
            check("issue_op1",       fpu_op1,         a);
            check("issue_op2",       fpu_op2,         b);
            fpu_data_valid = 1'($urandom_range(0, 1));
            fpu_result     = $urandom;
            for (int k = 0; k <= wait_n; k++) begin
                @(negedge clk);
                check("wait_rsp_valid", 32'(rsp_valid),  32'd0);
                check("wait_sel",       32'(fpu_op_sel), 32'(op));
                check("wait_op1",       fpu_op1,         a);
                check("wait_op2",       fpu_op2,         b);
                fpu_data_valid = (k == lat);
                fpu_result     = (k == lat) ? val : $urandom;
            end
            @(negedge clk);
        end
        if (legal && lat >= TO) exp_to++;

        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            check("rsp_valid",     32'(rsp_valid),  32'd1);
            check("rsp_result",    rsp_result,      exp_res);
            check("rsp_err",       32'(rsp_err),    32'(err));
            check("rsp_req_ready", 32'(req_ready),  32'd0);
            check("rsp_sel",       32'(fpu_op_sel), legal ? 32'(op) : 32'd7);
            if (legal) begin
                check("rsp_op1", fpu_op1, a);
                check("rsp_op2", fpu_op2, b);
            end
            fpu_data_valid = 1'($urandom_range(0, 1));
            fpu_result     = $urandom;
            rsp_ready      = (s == stall);
            req_valid      = (s < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_op         = 3'($urandom_range(0, 2));
            req_op1        = $urandom;
            req_op2        = $urandom;
        end
        exp_done++;
    endtask

    task automatic check_perf(input string tag);
`ifdef FPU_ISSUE_PERF_CNT_EN
        check({tag, "_ops_done"}, 32'(ops_done), 32'(exp_done));
        check({tag, "_timeouts"}, 32'(timeouts), 32'(exp_to));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        logic [2:0] op;
        rstn              = 1'b0;
        req_valid         = 1'b0;
        req_op            = 3'b000;
        req_op1           = 32'd0;
        req_op2           = 32'd0;
        fpu_result        = 32'd0;
        fpu_data_valid    = 1'b0;
        rsp_ready         = 1'b0;
        t4_req_valid      = 1'b0;
        t4_fpu_data_valid = 1'b0;
        t4_rsp_ready      = 1'b0;

        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        check_perf("reset");

        run_op(3'b000, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 0);
        run_op(3'b010, 32'h40000000, 32'h40400000, 5, 32'h40C00000, 0);
        run_op(3'b101, 32'h12345678, 32'h9ABCDEF0, 0, 32'hDEADBEEF, 0);
        run_op(3'b001, 32'h40A00000, 32'h3F800000, 2, 32'h40800000, 3);
        run_op(3'b000, 32'h11111111, 32'h22222222, TO + 3, 32'h33333333, 1);
        run_op(3'b010, 32'h44444444, 32'h55555555, TO - 1, 32'h66666666, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(3, 7));
            else                           op = 3'($urandom_range(0, 2));
            run_op(op, $urandom, $urandom, int'($urandom_range(0, TO + 2)), $urandom,
                   int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        check("final_idle_ready", 32'(req_ready), 32'd1);
        check("final_idle_sel",   32'(fpu_op_sel), 32'd7);
        check_perf("final");

        // Reset while waiting for the FPU: the operation must vanish.
        req_valid      = 1'b1;
        req_op         = 3'b000;
        req_op1        = 32'hCAFEF00D;
        req_op2        = 32'h0BADC0DE;
        fpu_data_valid = 1'b0;
        rsp_ready      = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_done = 0;
        exp_to   = 0;
        check_perf("midreset");
        fpu_data_valid = 1'b1;
        fpu_result     = 32'h7F7F7F7F;
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_reset_ready",     32'(req_ready), 32'd1);
            check("post_reset_sel",       32'(fpu_op_sel), 32'd7);
        end
        fpu_data_valid = 1'b0;

        // TIMEOUT = 4 instance: FPU never answers.
        req_op       = 3'b000;
        req_op1      = 32'h3F800000;
        req_op2      = 32'h3F800000;
        t4_req_valid = 1'b1;
        t4_rsp_ready = 1'b0;
        @(negedge clk);
        t4_req_valid = 1'b0;
        check("t4_issue_rsp_valid", 32'(t4_rsp_valid), 32'd0);
        for (int k = 0; k < TO4; k++) begin
            @(negedge clk);
            check("t4_wait_rsp_valid", 32'(t4_rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("t4_rsp_valid",  32'(t4_rsp_valid),  32'd1);
        check("t4_rsp_err",    32'(t4_rsp_err),    32'd1);
        check("t4_rsp_result", t4_rsp_result,      32'd0);
`ifdef FPU_ISSUE_PERF_CNT_EN
        check("t4_timeouts", 32'(t4_timeouts), 32'd1);
`endif
        t4_rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_idle_ready",     32'(t4_req_ready), 32'd1);
        check("t4_idle_rsp_valid", 32'(t4_rsp_valid), 32'd0);
`ifdef FPU_ISSUE_PERF_CNT_EN
        check("t4_ops_done", 32'(t4_ops_done), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
